// File: rtl/glip_credit_ctrl_if.sv
// Credit grant handshake between the credit controller (master) and the
// egress control-message encoder (slave).
interface glip_credit_ctrl_if #(
  parameter int TRANCHE_WIDTH = 14
) ();
  logic                     credit_valid;
  logic [TRANCHE_WIDTH-1:0] credit_val;
  logic                     credit_ready;

  modport master (output credit_valid, output credit_val, input credit_ready);
  modport slave  (input credit_valid, input credit_val, output credit_ready);
endinterface

// File: rtl/glip_credit_ctrl.sv
// Ingress credit controller for the GLIP UART backend: tracks free/granted
// space of the ingress FIFO and offers credit tranches to the remote side.
module glip_credit_ctrl #(
  parameter int CREDIT_WIDTH  = 15,
  parameter int BUFFER_DEPTH  = 512,
  parameter int REFILL_DIV    = 2,
  parameter int TRANCHE_WIDTH = 14,
  parameter int MAX_TRANCHE   = (1 << TRANCHE_WIDTH) - 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_clear,
  input  logic                    i_enable,
  input  logic                    i_transfer_in,
  input  logic                    i_fifo_pop,
  glip_credit_ctrl_if.master      credit,
  output logic [CREDIT_WIDTH-1:0] o_granted,
  output logic [CREDIT_WIDTH-1:0] o_avail,
  output logic                    o_error
);

  localparam int THRESH_I = (BUFFER_DEPTH / REFILL_DIV < 1) ? 1 : BUFFER_DEPTH / REFILL_DIV;
  // avail never exceeds the depth, so clamping the tranche limit there keeps
  // every grant representable in both counter and payload widths.
  localparam int MAXT_I   = (MAX_TRANCHE < BUFFER_DEPTH) ? MAX_TRANCHE : BUFFER_DEPTH;

  localparam logic [CREDIT_WIDTH-1:0] DEPTH_C  = CREDIT_WIDTH'(BUFFER_DEPTH);
  localparam logic [CREDIT_WIDTH-1:0] THRESH_C = CREDIT_WIDTH'(THRESH_I);
  localparam logic [CREDIT_WIDTH-1:0] MAXT_C   = CREDIT_WIDTH'(MAXT_I);

  typedef enum logic {S_IDLE, S_OFFER} state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [CREDIT_WIDTH-1:0]  r_avail;
  logic [CREDIT_WIDTH-1:0]  r_granted;
  logic [TRANCHE_WIDTH-1:0] r_val;
  logic                     r_error;

  logic [CREDIT_WIDTH-1:0]  w_occ;
  logic [CREDIT_WIDTH-1:0]  w_val_c;
  logic [CREDIT_WIDTH-1:0]  w_grant_amt;
  logic [CREDIT_WIDTH-1:0]  w_tranche;
  logic [CREDIT_WIDTH-1:0]  w_avail_nxt;
  logic [CREDIT_WIDTH-1:0]  w_granted_nxt;
  logic                     w_accept;
  logic                     w_xfer_ok;
  logic                     w_xfer_bad;
  logic                     w_pop_ok;
  logic                     w_pop_bad;
  logic                     w_trigger;
  logic                     w_load;

  assign w_occ      = DEPTH_C - r_avail - r_granted;
  assign w_accept   = (r_state == S_OFFER) & credit.credit_ready;

  // Faulting strobes are dropped; overrun is judged on the pre-acceptance
  // granted value even when a grant lands in the same cycle.
  assign w_xfer_ok  = i_transfer_in & (r_granted != '0);
  assign w_xfer_bad = i_transfer_in & (r_granted == '0);
  assign w_pop_ok   = i_fifo_pop & (w_occ != '0);
  assign w_pop_bad  = i_fifo_pop & (w_occ == '0);

  assign w_val_c       = CREDIT_WIDTH'(r_val);
  assign w_grant_amt   = w_accept ? w_val_c : '0;
  assign w_avail_nxt   = r_avail + CREDIT_WIDTH'(w_pop_ok) - w_grant_amt;
  assign w_granted_nxt = r_granted - CREDIT_WIDTH'(w_xfer_ok) + w_grant_amt;

  // Refill at the threshold, or hand out whatever is free once the remote
  // side has run dry so it can never stall on a sub-threshold remainder.
  assign w_trigger = i_enable & (r_avail != '0) &
                     ((r_avail >= THRESH_C) | (r_granted == '0));
  assign w_tranche = (r_avail < MAXT_C) ? r_avail : MAXT_C;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_trigger) begin
          w_state_nxt = S_OFFER;
          w_load      = 1'b1;
        end
      end
      S_OFFER: begin
        if (credit.credit_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_avail   <= DEPTH_C;
      r_granted <= '0;
      r_val     <= '0;
      r_error   <= 1'b0;
    end else if (i_clear) begin
      r_state   <= S_IDLE;
      r_avail   <= DEPTH_C;
      r_granted <= '0;
      r_val     <= '0;
      r_error   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_avail   <= w_avail_nxt;
      r_granted <= w_granted_nxt;
      if (w_load) r_val <= TRANCHE_WIDTH'(w_tranche);
      if (w_xfer_bad | w_pop_bad) r_error <= 1'b1;
    end
  end

  assign credit.credit_valid = (r_state == S_OFFER);
  assign credit.credit_val   = r_val;
  assign o_granted           = r_granted;
  assign o_avail             = r_avail;
  assign o_error             = r_error;

endmodule

// File: tb/tb_glip_credit_ctrl.sv
// Bench for glip_credit_ctrl: directed test-plan steps plus a random phase,
// all cycles checked against a behavioural credit model.
module tb_glip_credit_ctrl;
  localparam int CW   = 15;
  localparam int D    = 512;
  localparam int TW   = 14;
  localparam int TH   = 256;
  localparam int MAXT = 16383;

  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0, en = 1'b0, xfer = 1'b0, pop = 1'b0;
  logic clr2 = 1'b0, en2 = 1'b0, zero = 1'b0;
  logic [CW-1:0] granted, avail, granted2, avail2;
  logic err, err2;

  glip_credit_ctrl_if #(.TRANCHE_WIDTH(TW)) cif  ();
  glip_credit_ctrl_if #(.TRANCHE_WIDTH(TW)) cif2 ();

  glip_credit_ctrl #(.CREDIT_WIDTH(CW), .BUFFER_DEPTH(D), .REFILL_DIV(2),
                     .TRANCHE_WIDTH(TW), .MAX_TRANCHE(MAXT)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clr), .i_enable(en),
    .i_transfer_in(xfer), .i_fifo_pop(pop), .credit(cif),
    .o_granted(granted), .o_avail(avail), .o_error(err));

  glip_credit_ctrl #(.CREDIT_WIDTH(CW), .BUFFER_DEPTH(D), .REFILL_DIV(2),
                     .TRANCHE_WIDTH(TW), .MAX_TRANCHE(200)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clr2), .i_enable(en2),
    .i_transfer_in(zero), .i_fifo_pop(zero), .credit(cif2),
    .o_granted(granted2), .o_avail(avail2), .o_error(err2));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  // Reference: free space, credit at remote, pending offer, bytes held in FIFO.
  int m_a, m_g, m_val, m_occ;
  bit m_off, m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_a = D; m_g = 0; m_val = 0; m_off = 0; m_err = 0; m_occ = 0;
  endtask

  task automatic m_step();
    bit acc, x_ok, p_ok, trig;
    int grant;
    acc  = m_off && cif.credit_ready;
    x_ok = xfer && (m_g > 0);
    p_ok = pop && (m_occ > 0);
    if (xfer && !x_ok) m_err = 1;
    if (pop && !p_ok)  m_err = 1;
    trig  = !m_off && en && (m_a > 0) && (m_a >= TH || m_g == 0);
    grant = acc ? m_val : 0;
    m_a   = m_a + int'(p_ok) - grant;
    m_g   = m_g - int'(x_ok) + grant;
    m_occ = m_occ + int'(x_ok) - int'(p_ok);
    if (acc) m_off = 0;
    else if (trig) begin
      m_off = 1;
      m_val = (m_a - int'(p_ok) < MAXT) ? m_a - int'(p_ok) + grant : MAXT;
    end
  endtask

  task automatic check_all();
    check("credit_valid", cif.credit_valid, m_off);
    if (m_off) check("credit_val", cif.credit_val, m_val);
    check("avail", avail, m_a);
    check("granted", granted, m_g);
    check("error", err, m_err);
    check("invariant", avail + granted + m_occ, D);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n || clr) m_reset(); else m_step();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: observed no completion expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int offers2;
    cif.credit_ready  = 1'b0;
    cif2.credit_ready = 1'b1;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst valid", cif.credit_valid, 0);
    check("rst val", cif.credit_val, 0);
    check("rst avail", avail, D);
    check("rst granted", granted, 0);
    check("rst error", err, 0);
    check("rst2 avail", avail2, D);

    // First offer right after reset release, accepted immediately.
    en = 1; cif.credit_ready = 1; rst_n = 1;
    tick();
    check("first valid", cif.credit_valid, 1);
    check("first val", cif.credit_val, 512);
    tick();
    check("first granted", granted, 512);
    check("first avail", avail, 0);
    run(3);
    check("no reoffer", cif.credit_valid, 0);

    // Threshold refill with backpressure and pops during the wait.
    cif.credit_ready = 0;
    xfer = 1; run(300); xfer = 0;
    pop = 1; run(255); pop = 0;
    run(2);
    check("below thresh", cif.credit_valid, 0);
    pop = 1; tick(); pop = 0;
    tick();
    check("thresh valid", cif.credit_valid, 1);
    check("thresh val", cif.credit_val, 256);
    pop = 1; run(5); pop = 0; run(15);
    check("bp val", cif.credit_val, 256);
    check("bp valid", cif.credit_valid, 1);
    cif.credit_ready = 1; tick();
    check("bp avail", avail, 5);
    check("bp granted", granted, 468);
    run(4);
    check("bp no offer", cif.credit_valid, 0);

    // Transfer, pop and acceptance all in one cycle.
    clr = 1; tick(); clr = 0;
    cif.credit_ready = 1; run(2);
    check("sim granted0", granted, 512);
    cif.credit_ready = 0;
    xfer = 1; run(300); xfer = 0;
    pop = 1; run(256); pop = 0;
    tick();
    check("sim offer", cif.credit_val, 256);
    xfer = 1; pop = 1; cif.credit_ready = 1; tick();
    xfer = 0; pop = 0; cif.credit_ready = 0;
    check("sim granted", granted, 467);
    check("sim avail", avail, 1);

    // Starvation: partial grant once the remote side is out of credit.
    clr = 1; tick(); clr = 0;
    cif.credit_ready = 1; run(2); cif.credit_ready = 0;
    xfer = 1; run(512); xfer = 0;
    check("starve granted", granted, 0);
    check("starve no offer", cif.credit_valid, 0);
    en = 0; pop = 1; run(10); pop = 0; en = 1;
    tick();
    check("starve valid", cif.credit_valid, 1);
    check("starve val", cif.credit_val, 10);
    cif.credit_ready = 1; tick(); cif.credit_ready = 0;
    check("starve acc", granted, 10);

    // Faults and recovery through clear.
    en = 0; clr = 1; tick(); clr = 0;
    xfer = 1; tick(); xfer = 0;
    check("overrun err", err, 1);
    check("overrun granted", granted, 0);
    clr = 1; tick(); clr = 0;
    check("clr err", err, 0);
    pop = 1; tick(); pop = 0;
    check("underflow err", err, 1);
    check("underflow avail", avail, 512);
    en = 1; clr = 1; tick(); clr = 0;
    check("clr2 err", err, 0);
    check("clr2 avail", avail, 512);
    tick();
    check("reoffer val", cif.credit_val, 512);
    check("reoffer valid", cif.credit_valid, 1);

    // Tranche limit 200 on the second instance.
    clr2 = 1; @(posedge clk); #1; clr2 = 0; en2 = 1;
    offers2 = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (cif2.credit_valid) begin
        offers2++;
        check("mt val", cif2.credit_val, 200);
      end
    end
    check("mt offers", offers2, 2);
    check("mt avail", avail2, 112);
    check("mt granted", granted2, 400);
    check("mt valid", cif2.credit_valid, 0);

    // Random phase against the model; resync the model to the DUT via clear.
    clr = 1; tick(); clr = 0;
    for (int i = 0; i < 3000; i++) begin
      en   = ($urandom % 4) != 0;
      cif.credit_ready = $urandom % 2;
      xfer = (m_g != 0 && $urandom % 3 == 0) || ($urandom % 400 == 0);
      pop  = (m_occ != 0 && $urandom % 3 == 0) || ($urandom % 400 == 0);
      clr  = ($urandom % 250 == 0);
      tick();
    end
    clr = 0; xfer = 0; pop = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/glip_credit_ctrl.md
# glip_credit_ctrl

Parametrised ingress credit controller for the GLIP UART backend. It generalises the fixed half-FIFO refill of the UART control layer:
- buffer depth, refill threshold and maximum tranche size are parameters;
- it tracks buffer occupancy exactly;
- it issues a starvation-avoidance grant when the remote side runs out of credit;
- it detects over- and underflow.

It sits between the ingress FIFO (pop strobe), the remote-transfer strobe and the egress control-message encoder (credit handshake).

## Interface
- CREDIT_WIDTH, 15, width of internal counters; BUFFER_DEPTH must be < 2^CREDIT_WIDTH
- BUFFER_DEPTH, 512, ingress FIFO entries (total credit)
- REFILL_DIV, 2, refill threshold THRESH = BUFFER_DEPTH / REFILL_DIV (integer divide, min 1)
- TRANCHE_WIDTH, 14, width of credit message payload
- MAX_TRANCHE, 2^TRANCHE_WIDTH-1, largest single grant; 1..2^TRANCHE_WIDTH-1
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous soft reset (com reset); same effect as rst_n, one cycle
- enable  in  1  permits new offers; does not affect counting
- transfer_in  in  1  remote consumed one credit (one byte written into FIFO)
- fifo_pop  in  1  local consumer removed one byte from FIFO
- credit_valid  out  1  credit grant offered
- credit_val  out  TRANCHE_WIDTH  grant size; stable while credit_valid & !credit_ready
- credit_ready  in  1  encoder accepts grant
- granted  out  CREDIT_WIDTH  credit outstanding at remote
- avail  out  CREDIT_WIDTH  freed space not yet granted
- error  out  1  sticky fault flag

## Operation
- Invariant: avail + granted + occupancy = BUFFER_DEPTH, with occupancy = BUFFER_DEPTH - avail - granted.
- Reset (rst_n low or clear high): avail = BUFFER_DEPTH, granted = 0, state IDLE, credit_valid = 0, credit_val = 0, error = 0.
- Counting, every cycle, independent of state:
  - transfer_in: granted -= 1.
  - fifo_pop: avail += 1.
  - Both in the same cycle are both applied.
- Faults (event ignored, error set):
  - transfer_in with granted == 0 (overrun).
  - fifo_pop with occupancy == 0 (underflow).
- error is cleared only by reset or clear.
- State IDLE → OFFER when enable & avail != 0 & (avail >= THRESH | granted == 0).
  - The second term is starvation avoidance: a partial grant is issued when the remote side is out of credit.
  - On entry, latch credit_val = min(avail, MAX_TRANCHE), using the current-cycle avail before this cycle's pop.
- State OFFER: credit_valid = 1.
  - On credit_ready: avail -= credit_val, granted += credit_val, applied together with any same-cycle pop or transfer; → IDLE.
  - enable deasserting in OFFER does not withdraw the offer.
- A transfer_in in the acceptance cycle is counted against the pre-acceptance granted value, so an overrun is judged on the old value.

## Timing
- The offer is registered: credit_valid rises one cycle after the IDLE trigger condition holds.
- First offer after reset release: credit_valid = 1 on the 1st rising edge after rst_n high, provided enable = 1.
- Acceptance is the edge where credit_valid & credit_ready; credit_valid is low the following cycle. The minimum gap between offers is 1 low cycle.
- granted and avail update on the edge after the strobe. error is set on the edge after the faulting strobe.
- Reset mid-offer: credit_valid drops immediately (rst_n) or next edge (clear); no counter update from the pending grant.

## Test plan
- Reset, enable=1, credit_ready=1 → credit_valid on cycle 1 with credit_val=512; after acceptance granted=512, avail=0, then no further offer.
- From (granted=512, avail=0): 300 transfer_in, then 255 fifo_pop → no offer. The 256th pop → offer credit_val=256; after acceptance granted=468, avail=0.
- Starvation: from (granted=512, avail=0), 512 transfer_in, then 10 fifo_pop → granted=0, avail=10 → offer credit_val=10.
- Backpressure: offer 256 pending, credit_ready=0 for 20 cycles with 5 pops during the wait → credit_val stays 256. After acceptance avail=5, granted=468, and no new offer.
- Simultaneous: transfer_in, fifo_pop and acceptance in the same cycle → all three are applied. Repeat with MAX_TRANCHE=200: reset → offers 200, 200, then none; final avail=112, granted=400.
- Fault: transfer_in with granted=0 → error=1, granted stays 0; fifo_pop at occupancy 0 → error=1. Pulse clear → error=0, avail=512, and credit_val=512 is offered again.
